// File: rtl/mii_tx_sched_pkg.sv
// Shared definitions for the MII transmit scheduler: FSM state encoding,
// the fixed MII nibble values, and a small requester-index helper.
package mii_tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_JAM
    } tx_state_t;

    localparam logic [3:0] MII_PREAMBLE = 4'h5;
    localparam logic [3:0] MII_SFD      = 4'hD;
    localparam logic [3:0] MII_JAM      = 4'h5;

    // One-hot requester vector for a 1-bit requester index.
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mii_tx_arb.sv
// Two-way round-robin arbiter. When both requesters are asking, the one the
// priority pointer names wins; every accepted grant hands priority to the
// other requester.
module mii_tx_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    logic ptr;

    // Grant selection: the pointer only matters when both requesters ask.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        if (req[0] && req[1]) begin
            gnt_idx = ptr;
        end else begin
            gnt_idx = req[1];
        end
    end

    // Priority pointer moves away from whoever was just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~gnt_idx;
        end
    end

endmodule

// File: rtl/mii_tx_sched.sv
// mii_tx_sched: two-requester MII transmit scheduler in front of the PCS.
// Arbitrates whole frames, prepends preamble/SFD, and enforces the
// inter-packet gap and carrier deferral from the PCS crs output.
// Define MII_TX_COLLISION_EN to add jam-and-abort on col (half duplex);
// without it col is ignored and req_col stays 0.
module mii_tx_sched
    import mii_tx_sched_pkg::*;
#(
    parameter int IPG_NIBBLES      = 24,
    parameter int PREAMBLE_NIBBLES = 15,
    parameter int JAM_NIBBLES      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_data,
    input  logic [1:0] req_last,
    input  logic [1:0] req_err,
    output logic [1:0] req_ready,
    output logic [1:0] req_done,
    output logic [1:0] req_abort,
    output logic [1:0] req_col,
    input  logic       crs,
    input  logic       col,
    output logic       tx_en,
    output logic       tx_er,
    output logic [3:0] txd
);

    localparam int NIB_MAX = (PREAMBLE_NIBBLES > JAM_NIBBLES) ? PREAMBLE_NIBBLES : JAM_NIBBLES;
    localparam int CNT_W   = $clog2(NIB_MAX + 1);
    localparam int GAP_W   = $clog2(IPG_NIBBLES + 1);

    tx_state_t        state, state_next;
    logic [CNT_W-1:0] nib_cnt, cnt_next;
    logic [GAP_W-1:0] gap_cnt;
    logic             gnt, gnt_next;
    logic             tx_en_next, tx_er_next;
    logic [3:0]       txd_next;
    logic [1:0]       done_next, abort_next, col_next;
    logic             arb_idx, arb_valid, arb_accept;
    logic             sel_valid, sel_last, sel_err;
    logic [3:0]       sel_data;
    logic             start_ok;

    mii_tx_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .accept    (arb_accept),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign sel_valid = req_valid[gnt];
    assign sel_last  = req_last[gnt];
    assign sel_err   = req_err[gnt];
    assign sel_data  = req_data[{gnt, 2'b00} +: 4];
    assign start_ok  = arb_valid && !crs && (gap_cnt == GAP_W'(IPG_NIBBLES));

    // Gap counter: crs includes our own carrier, so this measures quiet time
    // since the PCS carrier last fell.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= GAP_W'(IPG_NIBBLES);
        end else if (ce) begin
            if (crs) begin
                gap_cnt <= '0;
            end else if (gap_cnt != GAP_W'(IPG_NIBBLES)) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Next-state and next-nibble logic; everything advances only on ce.
    always_comb begin
        state_next = state;
        cnt_next   = nib_cnt;
        gnt_next   = gnt;
        tx_en_next = tx_en;
        tx_er_next = tx_er;
        txd_next   = txd;
        done_next  = '0;
        abort_next = '0;
        col_next   = '0;
        req_ready  = '0;
        arb_accept = 1'b0;
        if (ce) begin
            case (state)
                ST_IDLE: begin
                    tx_en_next = 1'b0;
                    tx_er_next = 1'b0;
                    txd_next   = 4'h0;
                    if (start_ok) begin
                        arb_accept = 1'b1;
                        gnt_next   = arb_idx;
                        tx_en_next = 1'b1;
                        txd_next   = MII_PREAMBLE;
                        cnt_next   = CNT_W'(1);
                        state_next = ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    txd_next = MII_PREAMBLE;
                    cnt_next = nib_cnt + 1'b1;
                    if (nib_cnt == CNT_W'(PREAMBLE_NIBBLES - 1)) begin
                        state_next = ST_SFD;
                    end
                end
                ST_SFD: begin
                    txd_next   = MII_SFD;
                    state_next = ST_DATA;
                end
                ST_DATA: begin
                    req_ready = req_onehot(gnt);
                    if (sel_valid) begin
                        txd_next   = sel_data;
                        tx_er_next = sel_err;
                        if (sel_last) begin
                            done_next  = req_onehot(gnt);
                            state_next = ST_IDLE;
                        end
                    end else begin
                        txd_next   = 4'h0;
                        tx_er_next = 1'b1;
                        abort_next = req_onehot(gnt);
                        state_next = ST_IDLE;
                    end
                end
                ST_JAM: begin
`ifdef MII_TX_COLLISION_EN
                    tx_en_next = 1'b1;
                    tx_er_next = 1'b0;
                    txd_next   = MII_JAM;
                    cnt_next   = nib_cnt + 1'b1;
                    if (nib_cnt == CNT_W'(JAM_NIBBLES - 1)) begin
                        col_next   = req_onehot(gnt);
                        state_next = ST_IDLE;
                    end
`else
                    state_next = ST_IDLE;
`endif
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
`ifdef MII_TX_COLLISION_EN
            if (col && (state == ST_PREAMBLE || state == ST_SFD || state == ST_DATA)) begin
                req_ready  = '0;
                done_next  = '0;
                abort_next = '0;
                tx_en_next = 1'b1;
                tx_er_next = 1'b0;
                txd_next   = MII_JAM;
                cnt_next   = CNT_W'(1);
                state_next = ST_JAM;
            end
`endif
        end
    end

    // State, grant and registered MII outputs; reset truncates any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            nib_cnt   <= '0;
            gnt       <= 1'b0;
            tx_en     <= 1'b0;
            tx_er     <= 1'b0;
            txd       <= 4'h0;
            req_done  <= '0;
            req_abort <= '0;
            req_col   <= '0;
        end else begin
            state     <= state_next;
            nib_cnt   <= cnt_next;
            gnt       <= gnt_next;
            tx_en     <= tx_en_next;
            tx_er     <= tx_er_next;
            txd       <= txd_next;
            req_done  <= done_next;
            req_abort <= abort_next;
            req_col   <= col_next;
        end
    end

endmodule
